freq_gate_meter: RTL and testbench

Gated TTL frequency counter. Counts rising edges of an asynchronous TTL input during each high phase of a gate waveform supplied by the on-chip gate/strobe generator. It latches each window's count for the display and readout logic, and flags counter saturation and loss of the gate signal.

---
 rtl/freq_meas_pkg.sv | 21 ++
 rtl/sync_edge.sv | 40 ++++
 rtl/freq_gate_meter.sv | 165 ++++++++++++++++
 tb/tb_freq_gate_meter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meas_pkg.sv
// freq_meas_pkg
// Shared definitions for the frequency measurement blocks: the gated
// counter's state encoding and the default window/timeout constants that
// the gate generator also uses for its own timing.
package freq_meas_pkg;

   // Gated counter states: wait for a clean low gate, arm on the next rising
   // edge, count until the gate falls.
   typedef enum logic [1:0] {
      WAIT_LOW = 2'd0,
      ARM      = 2'd1,
      COUNT    = 2'd2
   } meas_state_e;

   // Default edge counter width (covers 100 MHz over a 1 s window).
   localparam int DEF_CNT_W   = 27;

   // Default gate watchdog limit in clock cycles.
   localparam int DEF_TIMEOUT = 50_000_000;

endpackage

// File: rtl/sync_edge.sv
// sync_edge
// Two-flop synchronizer for an asynchronous input, followed by one delay
// register for edge detection.
// Ports:
//   clock - system clock, rising edge
//   reset - asynchronous active-low reset
//   din   - asynchronous input
//   level - synchronized level
//   rise  - one-cycle strobe on a synchronized 0->1 transition
//   fall  - one-cycle strobe on a synchronized 1->0 transition
module sync_edge (
   input  logic clock,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic meta;
   logic dly;

   // meta/level form the synchronizer; dly holds the previous level so
   // edges can be seen as a difference between two adjacent samples.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         meta  <= 1'b0;
         level <= 1'b0;
         dly   <= 1'b0;
      end else begin
         meta  <= din;
         level <= meta;
         dly   <= level;
      end
   end

   assign rise = level & ~dly;
   assign fall = ~level & dly;

endmodule

// File: rtl/freq_gate_meter.sv
// freq_gate_meter
// Gated TTL frequency counter. Counts synchronized rising edges of sig_in
// while the gate is high, latches the count when the gate falls, flags
// saturation, and watches for a gate that has stopped toggling.
// Ports:
//   clock     - system clock, rising edge
//   reset     - asynchronous active-low reset
//   gate      - asynchronous gate waveform
//   sig_in    - asynchronous signal under test
//   freq_cnt  - edge count of the last completed window
//   cnt_valid - one-cycle pulse when freq_cnt updates
//   cnt_ovf   - last completed window saturated
//   busy      - a window is being counted
//   gate_lost - no gate edge seen for TIMEOUT cycles
module freq_gate_meter
   import freq_meas_pkg::*;
#(
   parameter int CNT_W   = DEF_CNT_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             gate,
   input  logic             sig_in,
   output logic [CNT_W-1:0] freq_cnt,
   output logic             cnt_valid,
   output logic             cnt_ovf,
   output logic             busy,
   output logic             gate_lost
);

   localparam int               TW       = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0]    T_MAX    = TW'(TIMEOUT);
   localparam logic [TW-1:0]    T_ONE    = TW'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic gate_s, gate_rise, gate_fall;
   logic sig_s, sig_rise, sig_fall;
   logic unused_sig_bits;

   meas_state_e      state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic             ovf, ovf_next;
   logic [CNT_W-1:0] freq_next;
   logic             cnt_ovf_next;
   logic             valid_next;
   logic [1:0]       warm;
   logic [TW-1:0]    timer;

   sync_edge u_gate_sync (
      .clock (clock),
      .reset (reset),
      .din   (gate),
      .level (gate_s),
      .rise  (gate_rise),
      .fall  (gate_fall)
   );

   sync_edge u_sig_sync (
      .clock (clock),
      .reset (reset),
      .din   (sig_in),
      .level (sig_s),
      .rise  (sig_rise),
      .fall  (sig_fall)
   );

   // Only the rising strobe of the signal path is needed.
   assign unused_sig_bits = sig_s ^ sig_fall;

   // The synchronizer flops come out of reset at 0, so gate_s reads low for
   // two cycles even if the real gate is high. warm marks when gate_s holds
   // a genuine sample, so a window already open at reset release is not
   // mistaken for a low gate followed by a fresh rising edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         warm <= 2'b00;
      end else begin
         warm <= {warm[0], 1'b1};
      end
   end

   // State, counter and result registers. busy follows the next state so it
   // is high exactly while the registered state is COUNT.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= WAIT_LOW;
         cnt       <= '0;
         ovf       <= 1'b0;
         freq_cnt  <= '0;
         cnt_ovf   <= 1'b0;
         cnt_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         ovf       <= ovf_next;
         freq_cnt  <= freq_next;
         cnt_ovf   <= cnt_ovf_next;
         cnt_valid <= valid_next;
         busy      <= (state_next == COUNT);
      end
   end

   // Window sequencing. The first edge of a window may arrive in the same
   // cycle as gate_rise, so ARM loads the counter with that edge rather than
   // clearing it. An edge coinciding with gate_fall belongs outside the
   // window and is dropped.
   always_comb begin
      state_next   = state;
      cnt_next     = cnt;
      ovf_next     = ovf;
      freq_next    = freq_cnt;
      cnt_ovf_next = cnt_ovf;
      valid_next   = 1'b0;
      unique case (state)
         WAIT_LOW: begin
            if (warm[1] && !gate_s) begin
               state_next = ARM;
            end
         end
         ARM: begin
            if (gate_rise) begin
               cnt_next   = {{(CNT_W-1){1'b0}}, sig_rise};
               ovf_next   = 1'b0;
               state_next = COUNT;
            end
         end
         COUNT: begin
            if (gate_fall) begin
               freq_next    = cnt;
               cnt_ovf_next = ovf;
               valid_next   = 1'b1;
               ovf_next     = 1'b0;
               state_next   = ARM;
            end else if (sig_rise) begin
               if (&cnt) begin
                  ovf_next = 1'b1;
               end else begin
                  cnt_next = cnt + CNT_ONE;
               end
            end
         end
         default: begin
            state_next = WAIT_LOW;
         end
      endcase
   end

   // Gate watchdog: cycles since the last gate edge, saturating at the
   // limit. It never touches the counting state; a window left open by a
   // dead gate just waits for the eventual fall.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         timer <= '0;
      end else if (gate_rise || gate_fall) begin
         timer <= '0;
      end else if (timer != T_MAX) begin
         timer <= timer + T_ONE;
      end
   end

   assign gate_lost = (timer == T_MAX);

endmodule

// File: tb/tb_freq_gate_meter.sv
// tb_freq_gate_meter
// Self-checking bench for freq_gate_meter with CNT_W=8, TIMEOUT=64.
// Each completed window pushes its expected count/overflow onto a queue;
// a monitor pops and compares on every cnt_valid pulse.
module tb_freq_gate_meter;

   localparam int CNT_W   = 8;
   localparam int TIMEOUT = 64;

   logic             clock = 1'b0;
   logic             reset;
   logic             gate;
   logic             sig_in;
   logic [CNT_W-1:0] freq_cnt;
   logic             cnt_valid;
   logic             cnt_ovf;
   logic             busy;
   logic             gate_lost;

   typedef struct packed {
      logic [CNT_W-1:0] cnt;
      logic             ovf;
   } exp_t;

   exp_t sb_q[$];
   int   errors = 0;
   int   checks = 0;

   freq_gate_meter #(
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .gate      (gate),
      .sig_in    (sig_in),
      .freq_cnt  (freq_cnt),
      .cnt_valid (cnt_valid),
      .cnt_ovf   (cnt_ovf),
      .busy      (busy),
      .gate_lost (gate_lost)
   );

   always #5 clock = ~clock;

   // Scoreboard monitor: every cnt_valid pulse must match the oldest
   // expected window result; a pulse with nothing expected is an error.
   always @(posedge clock) begin
      exp_t e;
      #1;
      if (cnt_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_valid: got freq_cnt=%0d, required no pulse", freq_cnt);
         end else begin
            e = sb_q.pop_front();
            checks++;
            if (freq_cnt !== e.cnt) begin
               errors++;
               $display("[TB] FAIL freq_cnt: got %0d, required %0d", freq_cnt, e.cnt);
            end
            checks++;
            if (cnt_ovf !== e.ovf) begin
               errors++;
               $display("[TB] FAIL cnt_ovf: got %0b, required %0b", cnt_ovf, e.ovf);
            end
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic push_exp(input int c, input bit o);
      exp_t e;
      e.cnt = CNT_W'(c);
      e.ovf = o;
      sb_q.push_back(e);
   endtask

   // One gate-high window with evenly spaced pulses, then gate low for a
   // while. Called at a negedge.
   task automatic window(input int high, input int edges, input int half,
                         input int lead, input bit report, input int exp_cnt,
                         input bit exp_ovf);
      gate = 1'b1;
      cycles(lead);
      repeat (edges) begin
         sig_in = 1'b1;
         cycles(half);
         sig_in = 1'b0;
         cycles(half);
      end
      cycles(high - lead - edges * 2 * half);
      if (report) push_exp(exp_cnt, exp_ovf);
      gate = 1'b0;
      cycles(10);
   endtask

   task automatic drain();
      int n = 0;
      while (sb_q.size() != 0 && n < 200) begin
         @(negedge clock);
         n++;
      end
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: %0d results still pending, required 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic test_reset();
      reset  = 1'b0;
      gate   = 1'b0;
      sig_in = 1'b0;
      cycles(3);
      checks++;
      if (freq_cnt !== '0) begin errors++; $display("[TB] FAIL reset_freq_cnt: got %0d, required 0", freq_cnt); end
      checks++;
      if (cnt_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_cnt_valid: got %0b, required 0", cnt_valid); end
      checks++;
      if (cnt_ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_cnt_ovf: got %0b, required 0", cnt_ovf); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b, required 0", busy); end
      checks++;
      if (gate_lost !== 1'b0) begin errors++; $display("[TB] FAIL reset_gate_lost: got %0b, required 0", gate_lost); end
      reset = 1'b1;
      cycles(6);
   endtask

   task automatic test_basic();
      checks++;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_idle: got %0b, required 0", busy); end
      gate = 1'b1;
      for (int i = 0; i < 10; i++) begin
         sig_in = 1'b1;
         cycles(5);
         sig_in = 1'b0;
         cycles(5);
         if (i == 5) begin
            checks++;
            if (busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy_window: got %0b, required 1", busy); end
         end
      end
      push_exp(10, 1'b0);
      gate = 1'b0;
      @(posedge clock);
      @(posedge clock);
      #1;
      checks++;
      if (cnt_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_valid_early: got %0b, required 0", cnt_valid); end
      @(posedge clock);
      #1;
      checks++;
      if (cnt_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid_timing: got %0b, required 1", cnt_valid); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_after: got %0b, required 0", busy); end
      @(posedge clock);
      #1;
      checks++;
      if (cnt_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_valid_width: got %0b, required 0", cnt_valid); end
      checks++;
      if (freq_cnt !== CNT_W'(10)) begin errors++; $display("[TB] FAIL basic_hold: got %0d, required 10", freq_cnt); end
      cycles(10);
      drain();
   endtask

   task automatic test_overflow();
      window(600, 300, 1, 0, 1'b1, 255, 1'b1);
      window(20, 5, 1, 2, 1'b1, 5, 1'b0);
      drain();
   endtask

   task automatic test_gate_at_reset();
      reset  = 1'b0;
      gate   = 1'b1;
      sig_in = 1'b0;
      cycles(2);
      reset = 1'b1;
      window(90, 20, 2, 4, 1'b0, 0, 1'b0);
      checks++;
      if (freq_cnt !== '0) begin errors++; $display("[TB] FAIL discarded_window: got %0d, required 0", freq_cnt); end
      window(30, 7, 1, 3, 1'b1, 7, 1'b0);
      drain();
   endtask

   task automatic test_reset_mid();
      gate = 1'b1;
      repeat (4) begin
         sig_in = 1'b1;
         cycles(2);
         sig_in = 1'b0;
         cycles(2);
      end
      checks++;
      if (busy !== 1'b1) begin errors++; $display("[TB] FAIL mid_busy: got %0b, required 1", busy); end
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if ({freq_cnt, cnt_valid, cnt_ovf, busy, gate_lost} !== '0) begin
         errors++;
         $display("[TB] FAIL mid_reset_outputs: got freq_cnt=%0d valid=%0b ovf=%0b busy=%0b lost=%0b, required all 0",
                  freq_cnt, cnt_valid, cnt_ovf, busy, gate_lost);
      end
      gate = 1'b0;
      cycles(3);
      reset = 1'b1;
      cycles(6);
      window(30, 3, 2, 2, 1'b1, 3, 1'b0);
      drain();
   endtask

   task automatic test_stuck_gate();
      window(10, 0, 1, 0, 1'b1, 0, 1'b0);
      gate = 1'b1;
      cycles(10);
      push_exp(0, 1'b0);
      gate = 1'b0;
      @(posedge clock);
      repeat (65) @(posedge clock);
      #1;
      checks++;
      if (gate_lost !== 1'b0) begin errors++; $display("[TB] FAIL lost_early: got %0b, required 0", gate_lost); end
      @(posedge clock);
      #1;
      checks++;
      if (gate_lost !== 1'b1) begin errors++; $display("[TB] FAIL lost_onset: got %0b, required 1", gate_lost); end
      repeat (33) @(posedge clock);
      #1;
      checks++;
      if (gate_lost !== 1'b1) begin errors++; $display("[TB] FAIL lost_hold: got %0b, required 1", gate_lost); end
      @(negedge clock);
      gate = 1'b1;
      @(posedge clock);
      @(posedge clock);
      #1;
      checks++;
      if (gate_lost !== 1'b1) begin errors++; $display("[TB] FAIL lost_clear_early: got %0b, required 1", gate_lost); end
      @(posedge clock);
      #1;
      checks++;
      if (gate_lost !== 1'b0) begin errors++; $display("[TB] FAIL lost_clear: got %0b, required 0", gate_lost); end
      cycles(10);
      push_exp(0, 1'b0);
      gate = 1'b0;
      cycles(10);
      drain();
   endtask

   task automatic test_no_signal();
      sig_in = 1'b1;
      cycles(5);
      window(50, 0, 1, 0, 1'b1, 0, 1'b0);
      sig_in = 1'b0;
      drain();
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_gate_at_reset();
      test_reset_mid();
      test_stuck_gate();
      test_no_signal();
      cycles(5);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
